stampa_scheduler: RTL

Bus-master controller that shares the character-printer interface between two requesters. It arbitrates round-robin between two character sources. For the winner, it polls the printer status register with I/O read cycles until the buffer-free flag is set, then issues an I/O write of the character. It sits between producer logic and the printer interface on the I/O bus: it drives `ior_`, `iow_` and `a15_a0`, and shares `d7_d0`.

---
 rtl/stampa_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/stampa_scheduler.sv
// -----------------------------------------------------------------------------
// stampa_scheduler
//   Bus master that shares a character printer between two requesters.
//   Arbitrates round-robin and latches the winner's character. It then polls
//   the printer status register with I/O reads until the buffer-free flag
//   (bit 5) is set, and writes the character to the data register.
//
// Ports
//   clock, reset     : single clock, synchronous active-high reset
//   req0/req1        : requester has a character pending
//   char0/char1      : character of each requester
//   ack0/ack1        : one-cycle pulse, that requester's character was written
//   busy             : transaction in progress (any state but IDLE)
//   ior_, iow_       : active-low I/O read / write strobes
//   a15_a0           : I/O address (BASE = status, BASE+1 = data)
//   d7_d0            : shared I/O data bus, driven only from WR through HOLD
// -----------------------------------------------------------------------------
module stampa_scheduler #(
    parameter logic [15:0] BASE          = 16'h0000,
    parameter int          STROBE_CYCLES = 2,
    parameter int          POLL_GAP      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  char0,
    input  logic [7:0]  char1,
    output logic        ack0,
    output logic        ack1,
    output logic        busy,
    output logic        ior_,
    output logic        iow_,
    output logic [15:0] a15_a0,
    inout  wire  [7:0]  d7_d0
);

    // One counter serves both strobe length and poll gap, so size it for the
    // larger of the two.
    localparam int MAXC = (STROBE_CYCLES > POLL_GAP) ? STROBE_CYCLES : POLL_GAP;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, RD, CHK, GAP, WR, HOLD, ACK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt_q, gnt_d;     // granted requester
    logic          last_q, last_d;   // last requester acknowledged
    logic          fo_q, fo_d;       // buffer-free flag from last poll
    logic [7:0]    char_q, char_d;

    // Bus outputs are registered from the next state so they switch on the
    // same edge as the state they belong to.
    logic          ior_q, ior_d, iow_q, iow_d, drv_q, drv_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic [15:0]   addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        fo_d    = fo_q;
        char_d  = char_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention pick the one not acknowledged last.
                    gnt_d   = (req0 && req1) ? ~last_q : req1;
                    char_d  = gnt_d ? char1 : char0;
                    cnt_d   = '0;
                    state_d = RD;
                end
            end
            RD: begin
                if (int'(cnt_q) == STROBE_CYCLES - 1) begin
                    fo_d    = d7_d0[5];
                    cnt_d   = '0;
                    state_d = CHK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHK: begin
                cnt_d = '0;
                if (fo_q)               state_d = WR;
                else if (POLL_GAP == 0) state_d = RD;
                else                    state_d = GAP;
            end
            GAP: begin
                if (int'(cnt_q) == POLL_GAP - 1) begin
                    cnt_d   = '0;
                    state_d = RD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR: begin
                if (int'(cnt_q) == STROBE_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: state_d = ACK;
            ACK: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ior_d  = (state_d != RD);
        iow_d  = (state_d != WR);
        drv_d  = (state_d == WR) || (state_d == HOLD);
        addr_d = drv_d ? BASE + 16'd1 : BASE;
        ack0_d = (state_d == ACK) && !gnt_d;
        ack1_d = (state_d == ACK) &&  gnt_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;   // favours requester 0 on first contention
            fo_q    <= 1'b0;
            char_q  <= 8'h00;
            ior_q   <= 1'b1;
            iow_q   <= 1'b1;
            drv_q   <= 1'b0;
            addr_q  <= BASE;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            fo_q    <= fo_d;
            char_q  <= char_d;
            ior_q   <= ior_d;
            iow_q   <= iow_d;
            drv_q   <= drv_d;
            addr_q  <= addr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign ior_   = ior_q;
    assign iow_   = iow_q;
    assign a15_a0 = addr_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign busy   = busy_q;
    assign d7_d0  = drv_q ? char_q : 8'hzz;

endmodule
